alu_seq: RTL and testbench

Parametrised, clocked successor to the 5-bit combinational ALU. It adds registered outputs, a start/busy/done handshake, XOR, logical shifts with carry-out, and an iterative shift-add multiplier, all at a configurable word width. It sits between the register-file read ports and the writeback mux of the multicycle datapath. The control FSM launches an operation and waits for `done`.

---
 rtl/alu_seq.sv | 137 +++++++++++++
 tb/tb_alu_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Clocked ALU with start/busy/done handshake: single-cycle ADD/SUB/logic/shift ops
// and a fixed-latency iterative shift-add multiplier, all at WIDTH bits.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags,
  output logic             state_dbg
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_LSL = 3'b110;
  localparam logic [2:0] OP_LSR = 3'b111;

  typedef enum logic {IDLE = 1'b0, MULT = 1'b1} state_t;

  // Handshake: start is only sampled while busy=0; done is a one-cycle pulse
  // marking the cycle in which Result/ALUFlags were just written.
  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [SH_W-1:0]  sh;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;
  logic [WIDTH-1:0] acc_next;

  assign state_dbg = state;

  always_comb begin
    sh     = b[SH_W-1:0];
    b_eff  = ALUControl[0] ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(ALUControl[0]);
    // One extra bit on each shift catches the last bit shifted out as carry.
    shl    = {1'b0, a} << sh;
    shr    = {a, 1'b0} >> sh;
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        op_res = sum[WIDTH-1:0];
        op_c   = sum[WIDTH];
        op_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ ALUControl[0]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_AND: op_res = a & b;
      OP_ORR: op_res = a | b;
      OP_EOR: op_res = a ^ b;
      OP_LSL: begin
        op_res = shl[WIDTH-1:0];
        op_c   = shl[WIDTH];
      end
      OP_LSR: begin
        op_res = shr[WIDTH:1];
        op_c   = shr[0];
      end
      default: op_res = '0;
    endcase
  end

  assign acc_next = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      Result   <= '0;
      ALUFlags <= 4'b0000;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (ALUControl == OP_MUL) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MULT;
            end else begin
              Result   <= op_res;
              ALUFlags <= {op_res[WIDTH-1], (op_res == '0), op_c, op_v};
              done     <= 1'b1;
            end
          end
        end
        MULT: begin
          // Fixed WIDTH iterations, even once the multiplier has drained to zero.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            Result   <= acc_next;
            ALUFlags <= {acc_next[WIDTH-1], (acc_next == '0), 2'b00};
            done     <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8 and WIDTH=32, with an expected-result
// queue filled at launch and drained when done pulses.
module tb_alu_seq;

  logic clk;
  logic reset;

  logic        start8, busy8, done8, st8;
  logic [7:0]  a8, b8, res8;
  logic [2:0]  op8;
  logic [3:0]  flags8;

  logic        start32, busy32, done32, st32;
  logic [31:0] a32, b32, res32;
  logic [2:0]  op32;
  logic [3:0]  flags32;

  logic [11:0] exp8_q[$];
  logic [35:0] exp32_q[$];

  int checks;
  int failures;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .ALUControl(op8),
    .busy(busy8), .done(done8), .Result(res8), .ALUFlags(flags8), .state_dbg(st8)
  );

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32), .ALUControl(op32),
    .busy(busy32), .done(done32), .Result(res32), .ALUFlags(flags32), .state_dbg(st32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {N,Z,C,V, result} for a w-bit ALU (w < 64).
  function automatic logic [67:0] model(input int w, input logic [2:0] op,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, av, bv, r;
    logic [64:0] s;
    logic c, v;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    av = a_in & mask;
    bv = b_in & mask;
    r = 64'd0;
    c = 1'b0;
    v = 1'b0;
    sh = int'(bv & 64'(w - 1));
    case (op)
      3'd0: begin
        s = {1'b0, av} + {1'b0, bv};
        r = s[63:0] & mask;
        c = s[w];
        v = (av[w-1] == bv[w-1]) && (r[w-1] != av[w-1]);
      end
      3'd1: begin
        s = {1'b0, av} + {1'b0, (~bv) & mask} + 65'd1;
        r = s[63:0] & mask;
        c = s[w];
        v = (av[w-1] != bv[w-1]) && (r[w-1] != av[w-1]);
      end
      3'd2: r = av & bv;
      3'd3: r = av | bv;
      3'd4: r = av ^ bv;
      3'd5: r = (av * bv) & mask;
      3'd6: begin
        r = (av << sh) & mask;
        c = (sh != 0) ? av[w-sh] : 1'b0;
      end
      default: begin
        r = av >> sh;
        c = (sh != 0) ? av[sh-1] : 1'b0;
      end
    endcase
    return {r[w-1], (r == 64'd0), c, v, r};
  endfunction

  task automatic drive8(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                        input logic [11:0] exp);
    @(negedge clk);
    start8 = 1'b1;
    op8 = op;
    a8 = av;
    b8 = bv;
    exp8_q.push_back(exp);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, res8, flags8, st8} !== 15'd0) begin
      failures++;
      $display("FAIL reset8 got busy=%b done=%b res=%h flags=%b st=%b required all 0",
               busy8, done8, res8, flags8, st8);
    end
    checks++;
    if ({busy32, done32, res32, flags32, st32} !== 39'd0) begin
      failures++;
      $display("FAIL reset32 got busy=%b done=%b res=%h flags=%b required all 0",
               busy32, done32, res32, flags32);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Single launches from the written test plan, each followed by a done-pulse check.
  task automatic test_single_ops;
    logic [2:0]  t_op[6]  = '{3'd0, 3'd1, 3'd1, 3'd6, 3'd7, 3'd6};
    logic [7:0]  t_a[6]   = '{8'h7F, 8'h05, 8'h00, 8'h81, 8'h81, 8'hA5};
    logic [7:0]  t_b[6]   = '{8'h01, 8'h05, 8'h01, 8'h01, 8'h09, 8'h00};
    logic [7:0]  t_r[6]   = '{8'h80, 8'h00, 8'hFF, 8'h02, 8'h40, 8'hA5};
    logic [3:0]  t_f[6]   = '{4'b1001, 4'b0110, 4'b1000, 4'b0010, 4'b0010, 4'b1000};
    logic [11:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive8(t_op[i], t_a[i], t_b[i], {t_f[i], t_r[i]});
      @(negedge clk);
      start8 = 1'b0;
      checks++;
      if (done8 !== 1'b1) begin
        failures++;
        $display("FAIL single_done[%0d] got=%b required=1", i, done8);
      end
      exp = exp8_q.pop_front();
      checks++;
      if ({flags8, res8} !== exp) begin
        failures++;
        $display("FAIL single_result[%0d] got flags=%b res=%h required flags=%b res=%h",
                 i, flags8, res8, exp[11:8], exp[7:0]);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || {flags8, res8} !== exp) begin
        failures++;
        $display("FAIL single_pulse[%0d] got done=%b res=%h required done=0 res=%h",
                 i, done8, res8, exp[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] t_op[3] = '{3'd2, 3'd3, 3'd4};
    logic [7:0] t_r[3]  = '{8'h30, 8'hFC, 8'hCC};
    logic [3:0] t_f[3]  = '{4'b0000, 4'b1000, 4'b1000};
    logic [11:0] exp;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (done8 !== 1'b1) begin
          failures++;
          $display("FAIL b2b_done[%0d] got=%b required=1", i, done8);
        end
        exp = exp8_q.pop_front();
        checks++;
        if ({flags8, res8} !== exp) begin
          failures++;
          $display("FAIL b2b_result[%0d] got flags=%b res=%h required flags=%b res=%h",
                   i, flags8, res8, exp[11:8], exp[7:0]);
        end
      end
      if (i < 3) begin
        start8 = 1'b1;
        op8 = t_op[i];
        a8 = 8'hF0;
        b8 = 8'h3C;
        exp8_q.push_back({t_f[i], t_r[i]});
      end else begin
        start8 = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_drop got=%b required=0", done8);
    end
  endtask

  task automatic test_random_ops;
    logic [2:0]  op;
    logic [7:0]  av, bv;
    logic [67:0] m;
    logic [11:0] exp;
    for (int i = 0; i <= 24; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (exp8_q.size() == 0) begin
          failures++;
          $display("FAIL rand_queue[%0d] got empty queue required entry", i);
        end else begin
          exp = exp8_q.pop_front();
          checks++;
          if (done8 !== 1'b1 || {flags8, res8} !== exp) begin
            failures++;
            $display("FAIL rand_op[%0d] got done=%b flags=%b res=%h required done=1 flags=%b res=%h",
                     i, done8, flags8, res8, exp[11:8], exp[7:0]);
          end
        end
      end
      if (i < 24) begin
        op = 3'($urandom_range(0, 6));
        if (op >= 3'd5) op = op + 3'd1;
        av = 8'($urandom_range(0, 255));
        bv = 8'($urandom_range(0, 255));
        m = model(8, op, 64'(av), 64'(bv));
        start8 = 1'b1;
        op8 = op;
        a8 = av;
        b8 = bv;
        exp8_q.push_back({m[67:64], m[7:0]});
      end else begin
        start8 = 1'b0;
      end
    end
  endtask

  // Launches a MUL, counts busy cycles, and fires an ignored ADD start mid-way.
  task automatic test_mul8(input logic [7:0] av, input logic [7:0] bv, input logic [11:0] exp_in);
    logic [11:0] prev, exp;
    int cycles;
    prev = {flags8, res8};
    drive8(3'd5, av, bv, exp_in);
    @(negedge clk);
    start8 = 1'b0;
    cycles = 0;
    while (busy8 === 1'b1 && cycles < 40) begin
      checks++;
      if (done8 !== 1'b0 || {flags8, res8} !== prev) begin
        failures++;
        $display("FAIL mul8_hold[%0d] got done=%b res=%h required done=0 res=%h",
                 cycles, done8, res8, prev[7:0]);
      end
      if (cycles == 3) begin
        start8 = 1'b1;
        op8 = 3'd0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
      end
      cycles++;
      @(negedge clk);
    end
    start8 = 1'b0;
    checks++;
    if (cycles != 8) begin
      failures++;
      $display("FAIL mul8_busy_cycles got=%0d required=8", cycles);
    end
    exp = exp8_q.pop_front();
    checks++;
    if (done8 !== 1'b1 || {flags8, res8} !== exp) begin
      failures++;
      $display("FAIL mul8_result got done=%b flags=%b res=%h required done=1 flags=%b res=%h",
               done8, flags8, res8, exp[11:8], exp[7:0]);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || {flags8, res8} !== exp) begin
      failures++;
      $display("FAIL mul8_after got done=%b busy=%b res=%h required done=0 busy=0 res=%h",
               done8, busy8, res8, exp[7:0]);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [11:0] exp;
    @(negedge clk);
    start8 = 1'b1;
    op8 = 3'd5;
    a8 = 8'hFF;
    b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, res8, flags8, st8} !== 15'd0) begin
      failures++;
      $display("FAIL mid_mul_reset got busy=%b done=%b res=%h flags=%b st=%b required all 0",
               busy8, done8, res8, flags8, st8);
    end
    @(negedge clk);
    reset = 1'b1;
    drive8(3'd0, 8'h12, 8'h34, 12'h046);
    @(negedge clk);
    start8 = 1'b0;
    exp = exp8_q.pop_front();
    checks++;
    if (done8 !== 1'b1 || {flags8, res8} !== exp) begin
      failures++;
      $display("FAIL post_reset_add got done=%b flags=%b res=%h required done=1 flags=%b res=%h",
               done8, flags8, res8, exp[11:8], exp[7:0]);
    end
  endtask

  task automatic test_w32;
    logic [2:0]  t_op[3] = '{3'd0, 3'd0, 3'd5};
    logic [31:0] t_a[3]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] t_b[3]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0009};
    logic [31:0] t_r[3]  = '{32'h8000_0000, 32'h0000_0000, 32'hA3D7_0A38};
    logic [3:0]  t_f[3]  = '{4'b1001, 4'b0110, 4'b1000};
    logic [31:0] av, bv;
    logic [67:0] m;
    logic [35:0] exp;
    int cycles;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start32 = 1'b1;
      if (i < 3) begin
        op32 = t_op[i];
        a32 = t_a[i];
        b32 = t_b[i];
        exp32_q.push_back({t_f[i], t_r[i]});
      end else begin
        av = $urandom();
        bv = $urandom();
        op32 = (i == 3) ? 3'd1 : 3'd5;
        a32 = av;
        b32 = bv;
        m = model(32, op32, 64'(av), 64'(bv));
        exp32_q.push_back({m[67:64], m[31:0]});
      end
      @(negedge clk);
      start32 = 1'b0;
      cycles = 0;
      while (busy32 === 1'b1 && cycles < 100) begin
        cycles++;
        @(negedge clk);
      end
      checks++;
      if (cycles != ((op32 == 3'd5) ? 32 : 0)) begin
        failures++;
        $display("FAIL w32_latency[%0d] got=%0d busy cycles required=%0d",
                 i, cycles, (op32 == 3'd5) ? 32 : 0);
      end
      exp = exp32_q.pop_front();
      checks++;
      if (done32 !== 1'b1 || {flags32, res32} !== exp) begin
        failures++;
        $display("FAIL w32_result[%0d] got done=%b flags=%b res=%h required done=1 flags=%b res=%h",
                 i, done32, flags32, res32, exp[35:32], exp[31:0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    op8 = '0;
    start32 = 1'b0;
    a32 = '0;
    b32 = '0;
    op32 = '0;
    test_reset;
    test_single_ops;
    test_back_to_back;
    test_random_ops;
    test_mul8(8'h10, 8'h11, 12'h010);
    for (int i = 0; i < 3; i++) begin
      logic [7:0]  av, bv;
      logic [67:0] m;
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      m = model(8, 3'd5, 64'(av), 64'(bv));
      test_mul8(av, bv, {m[67:64], m[7:0]});
    end
    test_reset_mid_mul;
    test_w32;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
